conv_pass_scheduler: RTL and testbench

Layer-level sequencer for the input-data fetch path. It walks a convolution layer as output tiles × input channels, and drives the window-fill controller with a start address, output offset and lane mask for each pass. It waits for each fill to complete, then hands off to the systolic array for compute and, after the last channel of a tile, for accumulator drain. It sits between the top-level layer control and the input ROM / fill-control pair.

---
 rtl/conv_pass_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_conv_pass_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pass_scheduler.sv
// Layer pass sequencer: walks output tiles x input channels, drives the window-fill
// controller for each pass, then hands off to the systolic array for compute and drain.
module conv_pass_scheduler #(
    parameter int array_size    = 9,
    parameter int dim_data_size = 16,
    parameter int addr_width    = 14
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [addr_width-1:0]    base_address_i,
    input  logic [addr_width-1:0]    channel_stride_i,
    input  logic [dim_data_size-1:0] num_channels_i,
    input  logic [dim_data_size-1:0] weight_size_i,
    input  logic [dim_data_size-1:0] image_height_i,
    input  logic [dim_data_size-1:0] image_width_i,
    input  logic                     fill_completed_i,
    input  logic                     compute_done_i,
    input  logic                     drain_done_i,
    output logic [addr_width-1:0]    fill_initial_address_o,
    output logic [dim_data_size-1:0] fill_offset_o,
    output logic [array_size-1:0]    fill_lane_mask_o,
    output logic                     fill_enable_o,
    output logic                     compute_start_o,
    output logic                     clear_acc_o,
    output logic                     drain_start_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);
    // state     | meaning
    // S_IDLE    | waiting for start
    // S_SETUP   | derive output dims and tile count, validate config
    // S_FILL    | fill controller loading windows for (tile, channel)
    // S_COMPUTE | array running the pass
    // S_NEXT    | advance channel or go drain
    // S_DRAIN   | accumulators being written out, then next tile
    // S_DONE    | one-cycle layer-complete flag
    // S_ERR     | bad config, one cycle then idle
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_FILL, S_COMPUTE, S_NEXT, S_DRAIN, S_DONE, S_ERR
    } state_t;

    localparam int TW = 2 * dim_data_size;
    localparam logic [dim_data_size-1:0] DIM_ONE  = dim_data_size'(1);
    localparam logic [TW-1:0]            POS_STEP = TW'(array_size);

    state_t                   state_q, state_d;
    logic [TW-1:0]            total_q, total_d;
    logic [TW-1:0]            pos_q, pos_d, pos_inc;
    logic [dim_data_size-1:0] chan_q, chan_d;
    logic [addr_width-1:0]    addr_q, addr_d;
    logic                     cstart_q, cstart_d;
    logic                     clr_q, clr_d;
    logic                     dstart_q, dstart_d;
    logic                     err_q, err_d;
    logic [addr_width-1:0]    fill_addr_q;
    logic [dim_data_size-1:0] fill_off_q;
    logic [array_size-1:0]    fill_mask_q, mask_next;
    logic [dim_data_size-1:0] out_h, out_w;
    logic [TW-1:0]            remaining;
    logic                     cfg_bad, load_fill;

    assign out_h   = image_height_i - weight_size_i + DIM_ONE;
    assign out_w   = image_width_i - weight_size_i + DIM_ONE;
    assign cfg_bad = (weight_size_i == '0) || (weight_size_i > image_height_i) ||
                     (weight_size_i > image_width_i) || (num_channels_i == '0);
    assign pos_inc = pos_q + POS_STEP;

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        pos_d    = pos_q;
        chan_d   = chan_q;
        addr_d   = addr_q;
        cstart_d = 1'b0;
        clr_d    = 1'b0;
        dstart_d = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SETUP;
                    err_d   = 1'b0;
                end
            end
            S_SETUP: begin
                total_d = TW'(out_h) * TW'(out_w);
                pos_d   = '0;
                chan_d  = '0;
                addr_d  = base_address_i;
                if (cfg_bad) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_completed_i) begin
                    state_d  = S_COMPUTE;
                    cstart_d = 1'b1;
                    clr_d    = (chan_q == '0);
                end
            end
            S_COMPUTE: begin
                // a done coinciding with our own start pulse belongs to no pass
                if (compute_done_i && !cstart_q) state_d = S_NEXT;
            end
            S_NEXT: begin
                if ((chan_q + DIM_ONE) < num_channels_i) begin
                    chan_d  = chan_q + DIM_ONE;
                    addr_d  = addr_q + channel_stride_i;
                    state_d = S_FILL;
                end else begin
                    state_d  = S_DRAIN;
                    dstart_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_done_i) begin
                    pos_d   = pos_inc;
                    chan_d  = '0;
                    addr_d  = base_address_i;
                    state_d = (pos_inc < total_q) ? S_FILL : S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane i is live while the tile still has more than i windows left.
    always_comb begin
        remaining = total_d - pos_d;
        mask_next = '0;
        for (int i = 0; i < array_size; i++) begin
            mask_next[i] = (remaining > TW'(i));
        end
    end

    assign load_fill = (state_d == S_FILL) && (state_q != S_FILL);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            total_q     <= '0;
            pos_q       <= '0;
            chan_q      <= '0;
            addr_q      <= '0;
            cstart_q    <= 1'b0;
            clr_q       <= 1'b0;
            dstart_q    <= 1'b0;
            err_q       <= 1'b0;
            fill_addr_q <= '0;
            fill_off_q  <= '0;
            fill_mask_q <= '0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            pos_q    <= pos_d;
            chan_q   <= chan_d;
            addr_q   <= addr_d;
            cstart_q <= cstart_d;
            clr_q    <= clr_d;
            dstart_q <= dstart_d;
            err_q    <= err_d;
            if (load_fill) begin
                fill_addr_q <= addr_d;
                fill_off_q  <= pos_d[dim_data_size-1:0];
                fill_mask_q <= mask_next;
            end
        end
    end

    assign fill_initial_address_o = fill_addr_q;
    assign fill_offset_o          = fill_off_q;
    assign fill_lane_mask_o       = fill_mask_q;
    assign fill_enable_o          = (state_q == S_FILL);
    assign compute_start_o        = cstart_q;
    assign clear_acc_o            = clr_q;
    assign drain_start_o          = dstart_q;
    assign busy_o                 = (state_q != S_IDLE);
    assign done_o                 = (state_q == S_DONE);
    assign error_o                = err_q;
endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Bench for conv_pass_scheduler: a procedural layer-walk model predicts every output
// each cycle under random handshakes; directed layers pin the model with literal values.
module tb_conv_pass_scheduler;
    localparam int AS = 9;
    localparam int DW = 16;
    localparam int AW = 14;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          start_cmd = 1'b0;
    logic          start_spur = 1'b0;
    logic          start_w;
    logic [AW-1:0] base_address, channel_stride;
    logic [DW-1:0] num_channels, weight_size, image_height, image_width;
    logic          fill_completed = 1'b0;
    logic          compute_done = 1'b0;
    logic          drain_done = 1'b0;
    logic [AW-1:0] fill_initial_address;
    logic [DW-1:0] fill_offset;
    logic [AS-1:0] fill_lane_mask;
    logic          fill_enable_o, compute_start_o, clear_acc_o, drain_start_o;
    logic          busy_o, done_o, error_o;

    logic hs_en = 1'b0;
    logic spur_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    assign start_w = start_cmd | start_spur;

    always #5 clk_i = ~clk_i;

    conv_pass_scheduler dut (
        .clk_i                  (clk_i),
        .rst_n_i                (rst_n_i),
        .start_i                (start_w),
        .base_address_i         (base_address),
        .channel_stride_i       (channel_stride),
        .num_channels_i         (num_channels),
        .weight_size_i          (weight_size),
        .image_height_i         (image_height),
        .image_width_i          (image_width),
        .fill_completed_i       (fill_completed),
        .compute_done_i         (compute_done),
        .drain_done_i           (drain_done),
        .fill_initial_address_o (fill_initial_address),
        .fill_offset_o          (fill_offset),
        .fill_lane_mask_o       (fill_lane_mask),
        .fill_enable_o          (fill_enable_o),
        .compute_start_o        (compute_start_o),
        .clear_acc_o            (clear_acc_o),
        .drain_start_o          (drain_start_o),
        .busy_o                 (busy_o),
        .done_o                 (done_o),
        .error_o                (error_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Random handshakes every cycle regardless of state, so stray pulses are exercised.
    always @(posedge clk_i) begin
        #2;
        if (hs_en) begin
            fill_completed = ($urandom_range(99) < 35);
            compute_done   = ($urandom_range(99) < 35);
            drain_done     = ($urandom_range(99) < 35);
        end else begin
            fill_completed = 1'b0;
            compute_done   = 1'b0;
            drain_done     = 1'b0;
        end
        start_spur = spur_en && compute_start_o;
    end

    // ---------------- reference model ----------------
    logic          ex_fe, ex_cs, ex_clr, ex_ds, ex_busy, ex_done, ex_err, ex_dv;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_off;
    logic [AS-1:0] ex_mask;
    logic          m_err, m_rst;

    task automatic exp_base(input logic busy);
        ex_fe = 0; ex_cs = 0; ex_clr = 0; ex_ds = 0; ex_done = 0; ex_dv = 0;
        ex_busy = busy; ex_err = m_err;
    endtask

    task automatic exp_reset();
        m_err = 0;
        exp_base(0);
        ex_addr = '0; ex_off = '0; ex_mask = '0;
    endtask

    task automatic mtick();
        @(posedge clk_i);
        m_rst = !rst_n_i;
        if (m_rst) exp_reset();
    endtask

    task automatic model_layer();
        int unsigned h, w, k, nch, base, stride, total, rem, n;
        m_err = 0;
        exp_base(1);
        mtick(); if (m_rst) return;
        h = image_height; w = image_width; k = weight_size; nch = num_channels;
        base = base_address; stride = channel_stride;
        if (k == 0 || k > h || k > w || nch == 0) begin
            m_err = 1;
            exp_base(1);
            mtick(); if (m_rst) return;
            exp_base(0);
            return;
        end
        total = (h - k + 1) * (w - k + 1);
        for (int unsigned pos = 0; pos < total; pos += AS) begin
            rem = total - pos;
            n = (rem < AS) ? rem : AS;
            for (int unsigned ch = 0; ch < nch; ch++) begin
                exp_base(1);
                ex_fe = 1; ex_dv = 1;
                ex_addr = AW'(base + ch * stride);
                ex_off  = DW'(pos);
                ex_mask = AS'((1 << n) - 1);
                do begin mtick(); if (m_rst) return; end while (!fill_completed);
                ex_fe = 0; ex_cs = 1; ex_clr = (ch == 0);
                mtick(); if (m_rst) return;
                ex_cs = 0; ex_clr = 0;
                do begin mtick(); if (m_rst) return; end while (!compute_done);
                exp_base(1);
                mtick(); if (m_rst) return;
            end
            ex_ds = 1;
            forever begin
                mtick(); if (m_rst) return;
                if (drain_done) break;
                ex_ds = 0;
            end
        end
        exp_base(1);
        ex_done = 1;
        mtick(); if (m_rst) return;
        exp_base(0);
    endtask

    initial begin
        exp_reset();
        forever begin
            mtick();
            if (!m_rst) begin
                if (start_w) model_layer();
                else exp_base(0);
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i === 1'b0) begin
            chk("rst_fill_enable", fill_enable_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_error", error_o, 0);
            chk("rst_addr", fill_initial_address, 0);
            chk("rst_mask", fill_lane_mask, 0);
        end else begin
            chk("fill_enable", fill_enable_o, ex_fe);
            chk("compute_start", compute_start_o, ex_cs);
            chk("clear_acc", clear_acc_o, ex_clr);
            chk("drain_start", drain_start_o, ex_ds);
            chk("busy", busy_o, ex_busy);
            chk("done", done_o, ex_done);
            chk("error", error_o, ex_err);
            if (ex_dv) begin
                chk("fill_addr", fill_initial_address, ex_addr);
                chk("fill_offset", fill_offset, ex_off);
                chk("fill_mask", fill_lane_mask, ex_mask);
            end
        end
    end

    // ---------------- monitor for literal checks ----------------
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_off[$];
    logic [AS-1:0] q_mask[$];
    logic          q_clr[$];
    int            n_drain = 0;
    int            n_done = 0;
    int            n_fe = 0;

    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            if (compute_start_o) begin
                q_addr.push_back(fill_initial_address);
                q_off.push_back(fill_offset);
                q_mask.push_back(fill_lane_mask);
                q_clr.push_back(clear_acc_o);
            end
            if (drain_start_o) n_drain++;
            if (done_o) n_done++;
            if (fill_enable_o) n_fe++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_cfg(input int h, input int w, input int k, input int ch,
                           input int base, input int stride);
        image_height   = DW'(h);
        image_width    = DW'(w);
        weight_size    = DW'(k);
        num_channels   = DW'(ch);
        base_address   = AW'(base);
        channel_stride = AW'(stride);
    endtask

    task automatic pulse_start();
        @(posedge clk_i); #2 start_cmd = 1'b1;
        @(posedge clk_i); #2 start_cmd = 1'b0;
    endtask

    task automatic run_layer(input int rst_after);
        logic fin;
        pulse_start();
        fin = 0;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk_i);
            if (rst_after != 0 && i == rst_after) begin
                #3 rst_n_i = 1'b0;
                repeat (2) @(negedge clk_i);
                #3 rst_n_i = 1'b1;
                fin = 1;
                break;
            end
            if (!busy_o) begin
                fin = 1;
                break;
            end
        end
        chk("layer_finished", fin, 1);
    endtask

    task automatic check_pass(input string tag, input int idx, input logic [AW-1:0] a,
                              input logic [DW-1:0] o, input logic [AS-1:0] m, input logic c);
        chk({tag, "_present"}, q_addr.size() > idx, 1);
        if (q_addr.size() > idx) begin
            chk({tag, "_addr"}, q_addr[idx], a);
            chk({tag, "_offset"}, q_off[idx], o);
            chk({tag, "_mask"}, q_mask[idx], m);
            chk({tag, "_clear_acc"}, q_clr[idx], c);
        end
    endtask

    task automatic scenario1(input string tag);
        int b, d0, n0;
        set_cfg(4, 4, 3, 2, 'h100, 'h010);
        b = q_addr.size(); d0 = n_drain; n0 = n_done;
        run_layer(0);
        chk({tag, "_passes"}, q_addr.size() - b, 2);
        check_pass({tag, "_p0"}, b, 'h100, 0, 'h00F, 1);
        check_pass({tag, "_p1"}, b + 1, 'h110, 0, 'h00F, 0);
        chk({tag, "_drains"}, n_drain - d0, 1);
        chk({tag, "_dones"}, n_done - n0, 1);
    endtask

    initial begin
        int b, d0, n0, f0, got;
        rst_n_i = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk_i);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_fill_enable", fill_enable_o, 0);
        #3 rst_n_i = 1'b1;
        hs_en = 1'b1;

        scenario1("s1");

        spur_en = 1'b1;
        set_cfg(6, 6, 3, 1, 'h0ABC, 'h0005);
        b = q_addr.size(); d0 = n_drain; n0 = n_done;
        run_layer(0);
        chk("s2_passes", q_addr.size() - b, 2);
        check_pass("s2_p0", b, 'h0ABC, 0, 'h1FF, 1);
        check_pass("s2_p1", b + 1, 'h0ABC, 9, 'h07F, 1);
        chk("s2_drains", n_drain - d0, 2);
        chk("s2_dones", n_done - n0, 1);

        set_cfg(4, 4, 3, 2, 'h3FF0, 'h0020);
        b = q_addr.size();
        run_layer(0);
        chk("s3_passes", q_addr.size() - b, 2);
        check_pass("s3_p0", b, 'h3FF0, 0, 'h00F, 1);
        check_pass("s3_p1", b + 1, 'h0010, 0, 'h00F, 0);

        set_cfg(4, 4, 5, 1, 'h100, 'h10);
        f0 = n_fe; n0 = n_done;
        run_layer(0);
        chk("err_k_flag", error_o, 1);
        chk("err_k_nofill", n_fe - f0, 0);
        chk("err_k_nodone", n_done - n0, 0);
        set_cfg(4, 4, 3, 0, 'h100, 'h10);
        f0 = n_fe;
        run_layer(0);
        chk("err_ch_flag", error_o, 1);
        chk("err_ch_nofill", n_fe - f0, 0);
        scenario1("s4");
        chk("err_cleared", error_o, 0);

        set_cfg(4, 4, 3, 2, 'h100, 'h010);
        pulse_start();
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (fill_enable_o) begin got = 1; break; end
        end
        chk("rstfill_reached", got, 1);
        d0 = n_drain;
        #1 rst_n_i = 1'b0;
        #1;
        chk("async_fill_enable", fill_enable_o, 0);
        chk("async_busy", busy_o, 0);
        chk("async_addr", fill_initial_address, 0);
        chk("async_offset", fill_offset, 0);
        chk("async_mask", fill_lane_mask, 0);
        repeat (3) @(negedge clk_i);
        #3 rst_n_i = 1'b1;
        chk("rstfill_no_drain", n_drain - d0, 0);
        scenario1("s5");

        for (int t = 0; t < 40; t++) begin
            set_cfg($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(0, 5),
                    $urandom_range(0, 3), $urandom_range(0, 16383), $urandom_range(0, 16383));
            run_layer(($urandom_range(0, 5) == 0) ? $urandom_range(3, 40) : 0);
        end

        hs_en = 1'b0;
        spur_en = 1'b0;
        repeat (3) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
